// File: rtl/spi_display_pkg.sv
// Shared constants for the 7-segment display SPI register controller.
// Build option: define SPI_DISPLAY_READBACK_EN to enable the READ command.
package spi_display_pkg;

  localparam int NUM_REGS_DEF = 10;
  localparam int ADDR_W_DEF   = 4;
  localparam int CNT_W_DEF    = 4;

  localparam int ENABLE_REG = 0;
  localparam int RADIX_REG  = 9;

  localparam int FRAME_W  = 16;
  localparam int BYTE_W   = 8;
  localparam int CNT_BITS = 5;

  localparam logic [3:0] CMD_NOP    = 4'h0;
  localparam logic [3:0] CMD_WRITE  = 4'h1;
  localparam logic [3:0] CMD_READ   = 4'h2;
  localparam logic [3:0] CMD_BURST  = 4'h3;
  localparam logic [3:0] CMD_CLEAR  = 4'h4;
  localparam logic [3:0] CMD_CLRERR = 4'h5;

  localparam int STS_ERR_ILLEGAL = 7;
  localparam int STS_ERR_ADDR    = 6;
  localparam int STS_ERR_SHORT   = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_BURST
  } frame_state_e;

endpackage

// File: rtl/spi_display_reg_ctrl_shifter.sv
// Bit counter and input shifter for one SPI frame; both are held clear while
// the slave is deselected or in reset, so a new frame always starts at zero.
module spi_frame_shifter
  import spi_display_pkg::*;
(
  input  logic                spi_sclk_i,
  input  logic                rst_low_i,
  input  logic                spi_ss_i,
  input  logic                spi_mosi_i,
  input  logic                wrap_i,
  output logic [CNT_BITS-1:0] cnt_o,
  output logic [BYTE_W-1:0]   rx_byte_o,
  output logic                first_edge_o,
  output logic                cmd_edge_o,
  output logic                byte_edge_o
);

  logic                clear;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [BYTE_W-2:0]   shift_q;

  assign clear = ~rst_low_i | spi_ss_i;

  // After a full frame, burst mode restarts the data byte; otherwise a new frame begins.
  always_comb begin
    if (cnt_q == CNT_BITS'(FRAME_W)) begin
      cnt_d = wrap_i ? CNT_BITS'(BYTE_W + 1) : CNT_BITS'(1);
    end else begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge spi_sclk_i or posedge clear) begin
    if (clear) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= {shift_q[BYTE_W-3:0], spi_mosi_i};
    end
  end

  assign cnt_o        = cnt_q;
  assign rx_byte_o    = {shift_q, spi_mosi_i};
  assign first_edge_o = ~spi_ss_i & (cnt_q == '0);
  assign cmd_edge_o   = ~spi_ss_i & (cnt_q == CNT_BITS'(BYTE_W - 1));
  assign byte_edge_o  = ~spi_ss_i & (cnt_q == CNT_BITS'(FRAME_W - 1));

endmodule

// File: rtl/spi_display_reg_ctrl.sv
// SPI slave controller owning the display shadow register file.
// Build option: SPI_DISPLAY_READBACK_EN enables READ; otherwise 0x2 is illegal.
module spi_display_reg_ctrl
  import spi_display_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                  spi_sclk_i,
  input  logic                  rst_low_i,
  input  logic                  spi_ss_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic                  update_toggle_o,
  output logic                  busy_o
);

  logic [CNT_BITS-1:0] cnt;
  logic [BYTE_W-1:0]   rx_byte;
  logic                first_edge, cmd_edge, byte_edge;
  frame_state_e        state;

  logic [7:0]        regs_q [NUM_REGS];
  logic [7:0]        regs_d [NUM_REGS];
  logic              toggle_q, toggle_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_addr_q, err_addr_d;
  logic              err_short_q, err_short_d;
  logic [15:0]       resp_q, resp_d;
  logic              in_frame_q, in_frame_d;
  logic              burst_q, burst_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [7:0]        hdr_q, hdr_d;

  logic [3:0]        hdr_cmd;
  logic [ADDR_W-1:0] hdr_addr;
  logic              addr_ok;
  logic              wrote, loaded;
  logic [7:0]        read_byte, status;
  logic [3:0]        miso_idx;

  spi_frame_shifter u_shifter (
    .spi_sclk_i   (spi_sclk_i),
    .rst_low_i    (rst_low_i),
    .spi_ss_i     (spi_ss_i),
    .spi_mosi_i   (spi_mosi_i),
    .wrap_i       (burst_q),
    .cnt_o        (cnt),
    .rx_byte_o    (rx_byte),
    .first_edge_o (first_edge),
    .cmd_edge_o   (cmd_edge),
    .byte_edge_o  (byte_edge)
  );

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (32'(a) == 32'(NUM_REGS - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  // burst_q goes stale while deselected, so the idle test comes first.
  assign state = (cnt == '0) ? ST_IDLE :
                 burst_q ? ST_BURST :
                 (cnt <= CNT_BITS'(BYTE_W)) ? ST_CMD : ST_DATA;

  assign hdr_cmd  = hdr_q[7:4];
  assign hdr_addr = hdr_q[ADDR_W-1:0];
  assign addr_ok  = 32'(hdr_addr) < 32'(NUM_REGS);

  always_ff @(posedge spi_sclk_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      regs_q        <= '{default: '0};
      toggle_q      <= 1'b0;
      wr_count_q    <= '0;
      err_illegal_q <= 1'b0;
      err_addr_q    <= 1'b0;
      err_short_q   <= 1'b0;
      resp_q        <= 16'h0000;
      in_frame_q    <= 1'b0;
      burst_q       <= 1'b0;
      baddr_q       <= '0;
      hdr_q         <= '0;
    end else begin
      regs_q        <= regs_d;
      toggle_q      <= toggle_d;
      wr_count_q    <= wr_count_d;
      err_illegal_q <= err_illegal_d;
      err_addr_q    <= err_addr_d;
      err_short_q   <= err_short_d;
      resp_q        <= resp_d;
      in_frame_q    <= in_frame_d;
      burst_q       <= burst_d;
      baddr_q       <= baddr_d;
      hdr_q         <= hdr_d;
    end
  end

  always_comb begin
    regs_d        = regs_q;
    toggle_d      = toggle_q;
    wr_count_d    = wr_count_q;
    err_illegal_d = err_illegal_q;
    err_addr_d    = err_addr_q;
    err_short_d   = err_short_q;
    resp_d        = resp_q;
    in_frame_d    = in_frame_q;
    burst_d       = burst_q;
    baddr_d       = baddr_q;
    hdr_d         = hdr_q;
    wrote         = 1'b0;
    loaded        = 1'b0;
    read_byte     = '0;
    status        = '0;

    // A frame that starts while the previous one never committed was cut short.
    if (first_edge) begin
      burst_d = 1'b0;
      if (in_frame_q) err_short_d = 1'b1;
    end
    if (!spi_ss_i) in_frame_d = 1'b1;
    if (cmd_edge) hdr_d = rx_byte;

    if (byte_edge) begin
      in_frame_d = 1'b0;
      if (state == ST_BURST) begin
        regs_d[baddr_q] = rx_byte;
        baddr_d         = addr_inc(baddr_q);
        wrote           = 1'b1;
      end else begin
        loaded = 1'b1;
        case (hdr_cmd)
          CMD_NOP: ;
          CMD_WRITE: begin
            if (addr_ok) begin
              regs_d[hdr_addr] = rx_byte;
              wrote            = 1'b1;
            end else begin
              err_addr_d = 1'b1;
            end
          end
`ifdef SPI_DISPLAY_READBACK_EN
          CMD_READ: begin
            if (addr_ok) read_byte = regs_q[hdr_addr];
            else         err_addr_d = 1'b1;
          end
`endif
          CMD_BURST: begin
            if (addr_ok) begin
              regs_d[hdr_addr] = rx_byte;
              baddr_d          = addr_inc(hdr_addr);
              burst_d          = 1'b1;
              wrote            = 1'b1;
            end else begin
              err_addr_d = 1'b1;
            end
          end
          CMD_CLEAR: begin
            regs_d = '{default: '0};
            wrote  = 1'b1;
          end
          CMD_CLRERR: begin
            err_illegal_d = 1'b0;
            err_addr_d    = 1'b0;
            err_short_d   = 1'b0;
          end
          default: err_illegal_d = 1'b1;
        endcase
      end
    end

    if (wrote) begin
      toggle_d   = ~toggle_q;
      wr_count_d = wr_count_q + CNT_W'(1);
    end

    status[STS_ERR_ILLEGAL] = err_illegal_d;
    status[STS_ERR_ADDR]    = err_addr_d;
    status[STS_ERR_SHORT]   = err_short_d;
    status[3:0]             = 4'(wr_count_d);
    if (loaded) resp_d = {status, read_byte};
  end

  // During burst bytes the response has already been sent, so MISO parks on bit 0.
  always_comb begin
    miso_idx = '0;
    if (state != ST_BURST && cnt < CNT_BITS'(FRAME_W)) begin
      miso_idx = 4'(CNT_BITS'(FRAME_W - 1) - cnt);
    end
    spi_miso_o = 1'b1;
    if (rst_low_i && !spi_ss_i) spi_miso_o = resp_q[miso_idx];
    busy_o = (state != ST_IDLE);
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[8*g +: 8] = regs_q[g];
  end

  assign update_toggle_o = toggle_q;

endmodule

// File: tb/tb_spi_display_reg_ctrl.sv
// Directed and randomized frames against a register-level model of the controller.
module tb_spi_display_reg_ctrl;
  import spi_display_pkg::*;

  localparam int NR = NUM_REGS_DEF;

  logic          spi_sclk_i;
  logic          rst_low_i;
  logic          spi_ss_i;
  logic          spi_mosi_i;
  logic          spi_miso_o;
  logic [8*NR-1:0] regs_o;
  logic          update_toggle_o;
  logic          busy_o;

  int checks;
  int errors;

  logic [7:0]  mRegs [NR];
  int          mCount;
  bit          mErrIll, mErrAddr, mErrShort, mToggle, mPartial, mBurst;
  int          mBurstAddr;
  logic [15:0] mResp;

  spi_display_reg_ctrl dut (
    .spi_sclk_i      (spi_sclk_i),
    .rst_low_i       (rst_low_i),
    .spi_ss_i        (spi_ss_i),
    .spi_mosi_i      (spi_mosi_i),
    .spi_miso_o      (spi_miso_o),
    .regs_o          (regs_o),
    .update_toggle_o (update_toggle_o),
    .busy_o          (busy_o)
  );

  task automatic checkOutput(input string tag, input logic [8*NR-1:0] observed,
                             input logic [8*NR-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [8*NR-1:0] modelImage();
    logic [8*NR-1:0] img;
    for (int i = 0; i < NR; i++) img[8*i +: 8] = mRegs[i];
    return img;
  endfunction

  function automatic logic [7:0] modelStatus();
    return {mErrIll, mErrAddr, mErrShort, 1'b0, 4'(mCount % 16)};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NR; i++) mRegs[i] = 8'h00;
    mCount = 0; mErrIll = 0; mErrAddr = 0; mErrShort = 0;
    mToggle = 0; mPartial = 0; mBurst = 0; mBurstAddr = 0;
    mResp = 16'h0000;
  endtask

  task automatic modelWrite();
    mToggle = ~mToggle;
    mCount  = (mCount + 1) % 16;
  endtask

  task automatic modelFrame(input logic [15:0] word);
    int         cmd, addr;
    logic [7:0] data, rd;
    cmd = int'(word[15:12]); addr = int'(word[11:8]); data = word[7:0];
    rd = 8'h00; mBurst = 0;
    case (cmd)
      0: ;
      1: if (addr < NR) begin mRegs[addr] = data; modelWrite(); end else mErrAddr = 1;
`ifdef SPI_DISPLAY_READBACK_EN
      2: if (addr < NR) rd = mRegs[addr]; else mErrAddr = 1;
`endif
      3: if (addr < NR) begin
           mRegs[addr] = data; modelWrite();
           mBurst = 1; mBurstAddr = (addr + 1) % NR;
         end else mErrAddr = 1;
      4: begin for (int i = 0; i < NR; i++) mRegs[i] = 8'h00; modelWrite(); end
      5: begin mErrIll = 0; mErrAddr = 0; mErrShort = 0; end
      default: mErrIll = 1;
    endcase
    mResp = {modelStatus(), rd};
  endtask

  task automatic shiftBits(input logic [15:0] word, input int n, output logic [15:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      spi_sclk_i = 1'b0;
      spi_mosi_i = word[15-i];
      #5;
      cap = {cap[14:0], spi_miso_o};
      spi_sclk_i = 1'b1;
      #5;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] word, input int nbits, input int nExtra,
                               input logic [23:0] extras, output logic [15:0] frameCap);
    logic [15:0] expResp, byteCap;
    logic [7:0]  b;
    logic        expBit;
    expResp = mResp;
    if (mPartial) mErrShort = 1;
    mPartial = (nbits < 16);
    spi_ss_i = 1'b0;
    #5;
    shiftBits(word, nbits, frameCap);
    checkOutput("miso_frame", (8*NR)'(frameCap), (8*NR)'(expResp >> (16 - nbits)));
    if (nbits == 16) modelFrame(word);
    for (int e = 0; e < nExtra; e++) begin
      b = extras[8*e +: 8];
      expBit = mResp[0];
      shiftBits({b, 8'h00}, 8, byteCap);
      checkOutput("miso_burst", (8*NR)'(byteCap[7:0]), (8*NR)'({8{expBit}}));
      if (mBurst) begin
        mRegs[mBurstAddr] = b;
        mBurstAddr = (mBurstAddr + 1) % NR;
        modelWrite();
      end
    end
    #5 spi_ss_i = 1'b1;
    #5;
    checkOutput("regs", regs_o, modelImage());
    checkOutput("toggle", (8*NR)'(update_toggle_o), (8*NR)'(mToggle));
    checkOutput("busy_idle", (8*NR)'(busy_o), (8*NR)'(1'b0));
    checkOutput("miso_idle", (8*NR)'(spi_miso_o), (8*NR)'(1'b1));
  endtask

  task automatic resetDut();
    rst_low_i = 1'b0;
    #10;
    rst_low_i = 1'b1;
    #10;
    modelReset();
  endtask

  initial begin
    logic [15:0] cap;
    int          r, cmd, addr;
    checks = 0; errors = 0;
    spi_sclk_i = 1'b1; spi_ss_i = 1'b1; spi_mosi_i = 1'b0; rst_low_i = 1'b0;
    modelReset();
    #20;
    checkOutput("reset_regs", regs_o, '0);
    checkOutput("reset_toggle", (8*NR)'(update_toggle_o), '0);
    checkOutput("reset_miso", (8*NR)'(spi_miso_o), (8*NR)'(1'b1));
    checkOutput("reset_busy", (8*NR)'(busy_o), '0);
    rst_low_i = 1'b1;
    #10;

    $display("[TB] write and read");
    applyStimulus(16'h1305, 16, 0, '0, cap);
    checkOutput("write_reg3", (8*NR)'(regs_o[8*3 +: 8]), (8*NR)'(8'h05));
    checkOutput("write_toggle", (8*NR)'(update_toggle_o), (8*NR)'(1'b1));
    applyStimulus(16'h2305, 16, 0, '0, cap);
    applyStimulus(16'h0000, 16, 0, '0, cap);
`ifdef SPI_DISPLAY_READBACK_EN
    checkOutput("read_resp", (8*NR)'(cap), (8*NR)'(16'h0105));
`else
    checkOutput("read_resp", (8*NR)'(cap), (8*NR)'(16'h8100));
`endif

    $display("[TB] burst");
    applyStimulus(16'h3811, 16, 2, {8'h00, 8'h33, 8'h22}, cap);
    checkOutput("burst_reg8", (8*NR)'(regs_o[8*8 +: 8]), (8*NR)'(8'h11));
    checkOutput("burst_reg9", (8*NR)'(regs_o[8*RADIX_REG +: 8]), (8*NR)'(8'h22));
    checkOutput("burst_reg0", (8*NR)'(regs_o[8*ENABLE_REG +: 8]), (8*NR)'(8'h33));

    $display("[TB] errors");
    resetDut();
    applyStimulus(16'h1C44, 16, 0, '0, cap);
    applyStimulus(16'h7000, 16, 0, '0, cap);
    applyStimulus(16'h0000, 16, 0, '0, cap);
    checkOutput("err_status", (8*NR)'(cap[15:8]), (8*NR)'(8'hC0));
    checkOutput("err_regs", regs_o, '0);
    applyStimulus(16'h5000, 16, 0, '0, cap);
    applyStimulus(16'h0000, 16, 0, '0, cap);
    checkOutput("clrerr_status", (8*NR)'(cap[15:8]), (8*NR)'(8'h00));

    $display("[TB] short frame");
    applyStimulus(16'h1201, 5, 0, '0, cap);
    applyStimulus(16'h0000, 16, 0, '0, cap);
    applyStimulus(16'h0000, 16, 0, '0, cap);
    checkOutput("short_flag", (8*NR)'(cap[13]), (8*NR)'(1'b1));

    $display("[TB] reset mid-frame");
    resetDut();
    spi_ss_i = 1'b0;
    #5;
    shiftBits(16'h1201, 10, cap);
    rst_low_i = 1'b0;
    #5;
    checkOutput("midrst_miso_low", (8*NR)'(spi_miso_o), (8*NR)'(1'b1));
    spi_ss_i = 1'b1;
    #5;
    rst_low_i = 1'b1;
    modelReset();
    #5;
    checkOutput("midrst_reg2", (8*NR)'(regs_o[8*2 +: 8]), '0);
    checkOutput("midrst_toggle", (8*NR)'(update_toggle_o), '0);
    checkOutput("midrst_miso", (8*NR)'(spi_miso_o), (8*NR)'(1'b1));
    applyStimulus(16'h0000, 16, 0, '0, cap);

    $display("[TB] random frames");
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        applyStimulus(16'($urandom()), $urandom_range(1, 15), 0, '0, cap);
      end else if (r <= 2) begin
        addr = $urandom_range(0, NR - 1);
        applyStimulus({4'h3, 4'(addr), 8'($urandom())}, 16, $urandom_range(0, 3),
                      24'($urandom()), cap);
      end else begin
        cmd  = $urandom_range(0, 7);
        addr = $urandom_range(0, 15);
        applyStimulus({4'(cmd), 4'(addr), 8'($urandom())}, 16, 0, '0, cap);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_display_reg_ctrl.md
Name: spi_display_reg_ctrl

Overview:
- SPI-slave protocol controller for the Nexys4 7-segment display register bank.
- Frames 16-bit SPI transactions and decodes command/address/data.
- Owns the shadow register file: reg 0 enable, regs 1-8 digits, reg 9 radices.
- Drives MISO with status and readback, and publishes the register image plus an update toggle for the 5 MHz display domain to resynchronise.

Parameters:
- NUM_REGS, 10, number of 8-bit display registers.
- ADDR_W, 4, address field width (upper-byte low nibble).
- CNT_W, 4, width of the committed-write counter reported in status.

Ports:
- spi_sclk_i  in  1  SPI clock; idle high; all state on posedge.
- rst_low_i  in  1  asynchronous active-low reset.
- spi_ss_i  in  1  slave select, active low, idle high.
- spi_mosi_i  in  1  serial data in, MSB first.
- spi_miso_o  out  1  serial data out; idle high.
- regs_o  out  8*NUM_REGS  flattened register image; reg n at [8n+7:8n].
- update_toggle_o  out  1  inverts once per committed write or clear.
- busy_o  out  1  high while a frame is in progress (bit count non-zero).

Behaviour:
- Interface: reset rst_low_i, asynchronous, active-low; clock spi_sclk_i.
- Reset values:
  - regs 0.
  - update_toggle_o 0.
  - status 0.
  - response register 16'h0000.
  - in_frame 0.
  - bit count 0.
  - spi_miso_o 1.
- Bit counter (5 bit) and input shift register:
  - Asynchronously cleared while rst_low_i low OR spi_ss_i high.
  - Sample MOSI on each posedge while ss low.
- States, derived from counter and burst flag:
  - IDLE (cnt 0).
  - CMD (cnt 1-8): upper byte latched at cnt 8.
  - DATA (cnt 9-16): frame commits on the 16th edge.
  - BURST: after commit of a BURST frame, every further 8 edges commit one byte; counter wraps 16 -> 9.
- Commands (upper byte [7:4]; addr = [3:0]; data = lower byte):
  - 0x0 NOP: no write.
  - 0x1 WRITE: reg[addr] <= data.
  - 0x2 READ: response lower byte of the next frame = reg[addr].
  - 0x3 BURST: reg[addr] <= data, then each subsequent byte goes to the next address. Address after NUM_REGS-1 wraps to 0.
  - 0x4 CLEAR: all regs <= 0.
  - 0x5 CLRERR: clears sticky error bits.
  - others: no effect, set err_illegal.
- Address rule: addr >= NUM_REGS on WRITE/READ/BURST start -> ignored, err_addr set; READ returns 0x00.
- Commit:
  - Register and update_toggle_o change on the same edge as the commit.
  - Each committed write/clear increments the write counter, mod 2^CNT_W.
  - Ignored commands do not toggle.
- Status byte: {err_illegal, err_addr, err_short, 1'b0, wr_count[3:0]}. Error bits are sticky until CLRERR or reset.
- Short frame:
  - in_frame is not cleared by ss. It is set on the first edge of a frame and cleared at each commit boundary.
  - If the first edge of a new frame finds in_frame set, set err_short, discard partial data, and process the new frame normally.
- MISO:
  - spi_miso_o = ss high ? 1 : resp_r[15 - cnt] (combinational mux on the counter).
  - So bit 15 is valid before the first edge, and each bit is valid from one posedge to the next.
  - resp_r is loaded at every 16-bit commit with {status_after_commit, read_byte}.
  - In BURST, resp_r is not reloaded after the first commit; the bit index saturates at 0.
- CDC contract: regs_o is stable from the toggle edge for at least 8 sclk periods. sclk < clock_5meg/2 guarantees the consumer's 2-flop toggle synchroniser sees a stable bus.
- Reset mid-frame aborts the frame with no commit. ss rising mid-frame discards the partial frame, detected as above.

Optional Feature:
- Macro SPI_DISPLAY_READBACK_EN.
- Defined: READ supported as above.
- Undefined:
  - 0x2 treated as illegal (err_illegal set).
  - Response lower byte always 0x00.
  - Status byte still returned.

Decomposition:
- Package spi_display_pkg:
  - Command code localparams (CMD_NOP..CMD_CLRERR).
  - NUM_REGS, ENABLE_REG=0, RADIX_REG=9.
  - Status bit indices.
  - Frame width 16.
- Sub-module spi_frame_shifter: shift register, async-ss-cleared bit counter, byte-boundary strobes.

Test Plan:
- WRITE frame 16'h1305 -> reg3 = 8'h05, update_toggle_o flips once, wr_count = 1; other regs unchanged.
- READ: frame 16'h2305 followed by NOP 16'h0000 -> second frame MISO = 16'h0105 (status wr_count 1, data 0x05).
- BURST: ss held low for 16'h3811, then 8'h22, 8'h33 -> reg8 = 11, reg9 = 22, reg0 = 33 (wrap); toggle flips 3 times.
- Bad address and illegal command: 16'h1C44 then 16'h7000, then NOP -> regs unchanged; status = 8'hC0; after CLRERR 16'h5000, next NOP status = 8'h00.
- Short frame: 5 bits then ss high, then 16'h0000 -> no write; following NOP reads status bit 5 (err_short) set.
- Reset: assert rst_low_i after 10 bits of 16'h1201 -> reg2 stays 0, toggle 0, spi_miso_o = 1 once ss is high.
